data_transposer: RTL and testbench

//  Converts a stream of packed, element-parallel XLEN-bit words into the bit-plane
//  (bit-transposed) layout used by the MVU data banks. NUM_WORDS elements are gathered,

---
 rtl/data_transposer.sv | 218 +++++++++++++++++++++
 tb/tb_data_transposer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_transposer.sv
// Gathers NUM_WORDS packed elements and emits them as bit-plane words (MSB plane first)
// onto the MVU data RAM write port, with partial-block flush when the stream ends.
module data_transposer #(
  parameter int NUM_WORDS     = 64,
  parameter int XLEN          = 32,
  parameter int MVU_ADDR_LEN  = 15,
  parameter int MVU_DATA_LEN  = 64,
  parameter int MAX_DATA_PREC = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             prec,
  input  logic [31:0]             baddr,
  input  logic [XLEN-1:0]         iword,
  input  logic                    start,
  output logic                    busy,
  output logic                    mvu_wr_en,
  output logic [MVU_ADDR_LEN-1:0] mvu_wr_addr,
  output logic [MVU_DATA_LEN-1:0] mvu_wr_word
);

  localparam int EPW = XLEN / MAX_DATA_PREC;
  localparam int WPB = NUM_WORDS / EPW;
  localparam int CW  = $clog2(WPB);
  localparam int PRW = $clog2(MAX_DATA_PREC + 1);
  localparam int PW  = $clog2(MAX_DATA_PREC);

  typedef logic [NUM_WORDS-1:0][MAX_DATA_PREC-1:0] blk_t;
  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, FLUSH = 2'd2} state_t;

  function automatic logic [MVU_DATA_LEN-1:0] plane_of(input blk_t blk, input logic [PW-1:0] b);
    logic [MVU_DATA_LEN-1:0] w;
    w = '0;
    for (int j = 0; j < NUM_WORDS; j++) begin
      w[j] = blk[j][b];
    end
    return w;
  endfunction

  state_t                  state_r, next_state_s;
  logic [PRW-1:0]          p_r, p_clamp_s, pm1_s, remm1_s, rem_r;
  logic [MVU_ADDR_LEN-1:0] ptr_r;
  logic [CW-1:0]           cnt_r;
  blk_t                    cap_r, shd_r, blk_s, launch_blk_s;
  logic                    pend_r, busy_r;
  logic                    load_s, sample_s, launch_s, set_pend_s, clr_pend_s;
  logic                    wr_en_r;
  logic [MVU_ADDR_LEN-1:0] wr_addr_r;
  logic [MVU_DATA_LEN-1:0] wr_word_r;
  logic                    unused_s;

  assign pm1_s    = p_r - PRW'(1);
  assign remm1_s  = rem_r - PRW'(1);
  assign unused_s = ^{baddr[31:MVU_ADDR_LEN], pm1_s[PRW-1], remm1_s[PRW-1]};

  // Precision clamp to 1..MAX_DATA_PREC
  always_comb begin
    if (prec == 32'd0) begin
      p_clamp_s = PRW'(1);
    end else if (prec > 32'(MAX_DATA_PREC)) begin
      p_clamp_s = PRW'(MAX_DATA_PREC);
    end else begin
      p_clamp_s = prec[PRW-1:0];
    end
  end

  // Capture buffer with the current input word merged into its lane slots
  always_comb begin
    blk_s = cap_r;
    for (int j = 0; j < NUM_WORDS; j++) begin
      if (CW'(j / EPW) == cnt_r) begin
        blk_s[j] = iword[(j % EPW) * MAX_DATA_PREC +: MAX_DATA_PREC];
      end else begin
        blk_s[j] = cap_r[j];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state and control strobes
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    sample_s     = 1'b0;
    launch_s     = 1'b0;
    launch_blk_s = blk_s;
    set_pend_s   = 1'b0;
    clr_pend_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s       = 1'b1;
          next_state_s = CAPTURE;
        end else begin
          next_state_s = IDLE;
        end
      end
      CAPTURE: begin
        if (start) begin
          sample_s = 1'b1;
          if (cnt_r == CW'(WPB - 1)) begin
            launch_s = 1'b1;
          end else begin
            launch_s = 1'b0;
          end
        end else begin
          // A partial block may have to wait for the previous block's planes to drain
          set_pend_s   = (cnt_r != '0);
          next_state_s = FLUSH;
        end
      end
      FLUSH: begin
        if (rem_r == '0) begin
          if (pend_r) begin
            launch_s     = 1'b1;
            launch_blk_s = cap_r;
            clr_pend_s   = 1'b1;
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          next_state_s = FLUSH;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Session parameters, capture buffer and element counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r    <= PRW'(1);
      cnt_r  <= '0;
      cap_r  <= '0;
      pend_r <= 1'b0;
    end else begin
      if (load_s) begin
        p_r   <= p_clamp_s;
        cnt_r <= '0;
        cap_r <= '0;
      end else if (sample_s) begin
        if (cnt_r == CW'(WPB - 1)) begin
          cnt_r <= '0;
          cap_r <= '0;
        end else begin
          cnt_r <= cnt_r + CW'(1);
          cap_r <= blk_s;
        end
      end else begin
        cnt_r <= cnt_r;
        cap_r <= cap_r;
      end
      if (load_s || clr_pend_s) begin
        pend_r <= 1'b0;
      end else if (set_pend_s) begin
        pend_r <= 1'b1;
      end else begin
        pend_r <= pend_r;
      end
    end
  end

  // Plane emitter: the first plane comes straight from the launched block, the rest from shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_r     <= '0;
      rem_r     <= '0;
      ptr_r     <= '0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_word_r <= '0;
    end else if (load_s) begin
      ptr_r   <= baddr[MVU_ADDR_LEN-1:0];
      rem_r   <= '0;
      wr_en_r <= 1'b0;
    end else if (launch_s) begin
      shd_r     <= launch_blk_s;
      rem_r     <= pm1_s;
      wr_en_r   <= 1'b1;
      wr_addr_r <= ptr_r;
      wr_word_r <= plane_of(launch_blk_s, pm1_s[PW-1:0]);
      ptr_r     <= ptr_r + MVU_ADDR_LEN'(1);
    end else if (rem_r != '0) begin
      rem_r     <= remm1_s;
      wr_en_r   <= 1'b1;
      wr_addr_r <= ptr_r;
      wr_word_r <= plane_of(shd_r, remm1_s[PW-1:0]);
      ptr_r     <= ptr_r + MVU_ADDR_LEN'(1);
    end else begin
      wr_en_r <= 1'b0;
    end
  end

  // Busy tracks the session until the FSM is back in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (next_state_s != IDLE);
    end
  end

  assign busy        = busy_r;
  assign mvu_wr_en   = wr_en_r;
  assign mvu_wr_addr = wr_addr_r;
  assign mvu_wr_word = wr_word_r;

endmodule

// File: tb/tb_data_transposer.sv
// Randomized self-checking bench for data_transposer against a plain-arithmetic
// model that computes every expected bit-plane write from the element values.
module tb_data_transposer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] prec = 32'd0;
  logic [31:0] baddr = 32'd0;
  logic [31:0] iword = 32'd0;
  logic        start = 1'b0;
  logic        busy, mvu_wr_en;
  logic [14:0] mvu_wr_addr;
  logic [63:0] mvu_wr_word;

  data_transposer dut (
    .clk(clk), .rst_n(rst_n), .prec(prec), .baddr(baddr), .iword(iword), .start(start),
    .busy(busy), .mvu_wr_en(mvu_wr_en), .mvu_wr_addr(mvu_wr_addr), .mvu_wr_word(mvu_wr_word)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] words[$];
  logic [14:0] wa_q[$];
  logic [63:0] ww_q[$];
  int          wc_q[$];
  logic [14:0] exp_a[$];
  logic [63:0] exp_w[$];
  bit  s_tout, s_busy_ok;
  int  s_t16;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (rst_n && mvu_wr_en) begin
      wa_q.push_back(mvu_wr_addr);
      ww_q.push_back(mvu_wr_word);
      wc_q.push_back(cyc);
    end
  end

  // Reference: element e lives in word e/4, lane e%4; block k plane b goes to A+k*P+(P-1-b).
  function automatic void build_expected(input int pr, input int ba, input int n);
    int p, nblk, e;
    logic [7:0]  v;
    logic [63:0] w;
    p = (pr <= 0) ? 1 : ((pr > 8) ? 8 : pr);
    nblk = (n + 15) / 16;
    exp_a.delete();
    exp_w.delete();
    for (int k = 0; k < nblk; k++) begin
      for (int b = p - 1; b >= 0; b--) begin
        w = 64'd0;
        for (int j = 0; j < 64; j++) begin
          e = k * 64 + j;
          if (e / 4 < n) begin
            v = 8'((words[e / 4] >> (8 * (e % 4))) & 32'hFF);
            w[j] = v[b];
          end
        end
        exp_w.push_back(w);
        exp_a.push_back(15'((ba + k * p + (p - 1 - b)) & 32'h7FFF));
      end
    end
  endfunction

  task automatic run_session(input int pr, input int ba, input int n,
                             output bit tout, output bit busy_ok, output int t16);
    wa_q.delete(); ww_q.delete(); wc_q.delete();
    t16 = -1;
    @(negedge clk);
    prec = 32'(pr); baddr = 32'(ba); start = 1'b1; iword = $urandom;
    @(negedge clk);
    busy_ok = (busy === 1'b1);
    for (int i = 0; i < n; i++) begin
      iword = words[i];
      @(negedge clk);
      if (i == 15) t16 = cyc;
      prec = $urandom; baddr = $urandom;
    end
    start = 1'b0; iword = $urandom;
    tout = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (busy === 1'b0) begin
        tout = 1'b0;
        break;
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (mvu_wr_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", mvu_wr_en); end
    checks++; if (mvu_wr_addr !== 15'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", mvu_wr_addr); end
    checks++; if (mvu_wr_word !== 64'd0) begin errors++; $display("FAIL reset_word got %h want 0", mvu_wr_word); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (wa_q.size() != 0) begin errors++; $display("FAIL reset_nowrites got %0d want 0", wa_q.size()); end
  endtask

  task automatic test_basic;
    words.delete();
    for (int w = 0; w < 16; w++)
      words.push_back({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    build_expected(6, 0, 16);
    run_session(6, 0, 16, s_tout, s_busy_ok, s_t16);
    checks++; if (s_busy_ok !== 1'b1) begin errors++; $display("FAIL basic_busy got 0 want 1"); end
    checks++; if (s_tout) begin errors++; $display("FAIL basic_busy_drop got timeout want idle"); end
    checks++; if (wa_q.size() != 6) begin errors++; $display("FAIL basic_count got %0d want 6", wa_q.size()); end
    if (wa_q.size() == 6) begin
      checks++; if (ww_q[0] !== 64'hFFFFFFFF00000000) begin errors++; $display("FAIL basic_plane5 got %h want ffffffff00000000", ww_q[0]); end
      checks++; if (ww_q[5] !== 64'hAAAAAAAAAAAAAAAA) begin errors++; $display("FAIL basic_plane0 got %h want aaaaaaaaaaaaaaaa", ww_q[5]); end
      checks++; if (wc_q[0] != s_t16) begin errors++; $display("FAIL basic_latency got cycle %0d want %0d", wc_q[0], s_t16); end
    end
    for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== exp_a[i] || ww_q[i] !== exp_w[i]) begin
        errors++; $display("FAIL basic_write%0d got %0d:%h want %0d:%h", i, wa_q[i], ww_q[i], exp_a[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_full_prec;
    words.delete();
    for (int w = 0; w < 32; w++) words.push_back(32'hFFFFFFFF);
    build_expected(8, 100, 32);
    run_session(8, 100, 32, s_tout, s_busy_ok, s_t16);
    checks++; if (wa_q.size() != 16) begin errors++; $display("FAIL prec8_count got %0d want 16", wa_q.size()); end
    for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== exp_a[i] || ww_q[i] !== 64'hFFFFFFFFFFFFFFFF) begin
        errors++; $display("FAIL prec8_write%0d got %0d:%h want %0d:%h", i, wa_q[i], ww_q[i], exp_a[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_clamp;
    int pr_tab[2] = '{0, 20};
    int cnt_tab[2] = '{1, 8};
    for (int t = 0; t < 2; t++) begin
      words.delete();
      for (int w = 0; w < 16; w++) words.push_back($urandom);
      build_expected(pr_tab[t], 40, 16);
      run_session(pr_tab[t], 40, 16, s_tout, s_busy_ok, s_t16);
      checks++; if (wa_q.size() != cnt_tab[t]) begin errors++; $display("FAIL clamp%0d_count got %0d want %0d", pr_tab[t], wa_q.size(), cnt_tab[t]); end
      for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) begin
        checks++;
        if (wa_q[i] !== exp_a[i] || ww_q[i] !== exp_w[i]) begin
          errors++; $display("FAIL clamp%0d_write%0d got %0d:%h want %0d:%h", pr_tab[t], i, wa_q[i], ww_q[i], exp_a[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_flush;
    words.delete();
    for (int w = 0; w < 5; w++) words.push_back($urandom);
    build_expected(4, 7, 5);
    run_session(4, 7, 5, s_tout, s_busy_ok, s_t16);
    checks++; if (s_tout) begin errors++; $display("FAIL flush_busy_drop got timeout want idle"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    checks++; if (wa_q.size() != 4) begin errors++; $display("FAIL flush_count got %0d want 4", wa_q.size()); end
    for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== exp_a[i] || ww_q[i] !== exp_w[i] || (ww_q[i] >> 20) !== 64'd0) begin
        errors++; $display("FAIL flush_write%0d got %0d:%h want %0d:%h", i, wa_q[i], ww_q[i], exp_a[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_wrap;
    logic [14:0] wrap_tab[4] = '{15'd32766, 15'd32767, 15'd0, 15'd1};
    words.delete();
    for (int w = 0; w < 16; w++) words.push_back($urandom);
    build_expected(4, 32766, 16);
    run_session(4, 32766, 16, s_tout, s_busy_ok, s_t16);
    checks++; if (wa_q.size() != 4) begin errors++; $display("FAIL wrap_count got %0d want 4", wa_q.size()); end
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== wrap_tab[i] || ww_q[i] !== exp_w[i]) begin
        errors++; $display("FAIL wrap_write%0d got %0d:%h want %0d:%h", i, wa_q[i], ww_q[i], wrap_tab[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_reset_mid_emit;
    int n_before;
    wa_q.delete(); ww_q.delete(); wc_q.delete();
    @(negedge clk);
    prec = 32'd8; baddr = 32'd500; start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      iword = $urandom;
      @(negedge clk);
    end
    @(negedge clk);
    n_before = wa_q.size();
    rst_n = 1'b0;
    #1;
    checks++; if (mvu_wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_en got %b want 0", mvu_wr_en); end
    start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (wa_q.size() != n_before) begin errors++; $display("FAIL rstmid_writes got %0d want %0d", wa_q.size(), n_before); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int pr, ba, n;
    for (int it = 0; it < 7; it++) begin
      pr = (it == 0) ? 8 : int'($urandom_range(0, 10));
      ba = (it == 0) ? 32760 : int'($urandom);
      n  = (it == 0) ? 18 : int'($urandom_range(1, 40));
      words.delete();
      for (int w = 0; w < n; w++) words.push_back($urandom);
      build_expected(pr, ba, n);
      run_session(pr, ba, n, s_tout, s_busy_ok, s_t16);
      checks++; if (s_tout) begin errors++; $display("FAIL b2b%0d_busy_drop got timeout want idle", it); end
      checks++; if (wa_q.size() != exp_a.size()) begin errors++; $display("FAIL b2b%0d_count got %0d want %0d", it, wa_q.size(), exp_a.size()); end
      for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) begin
        checks++;
        if (wa_q[i] !== exp_a[i] || ww_q[i] !== exp_w[i]) begin
          errors++; $display("FAIL b2b%0d_write%0d got %0d:%h want %0d:%h", it, i, wa_q[i], ww_q[i], exp_a[i], exp_w[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_prec();
    test_clamp();
    test_flush();
    test_wrap();
    test_reset_mid_emit();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
